// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator-processor control unit: opcodes, FSM states,
// datapath select codes and the packed control word driven to the datapath.
package ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_AND   = 5'h03;
  localparam logic [4:0] OP_OR    = 5'h04;
  localparam logic [4:0] OP_ADDI  = 5'h05;
  localparam logic [4:0] OP_LDI   = 5'h06;
  localparam logic [4:0] OP_LOAD  = 5'h07;
  localparam logic [4:0] OP_STORE = 5'h08;
  localparam logic [4:0] OP_BEQZ  = 5'h09;
  localparam logic [4:0] OP_BNEZ  = 5'h0A;
  localparam logic [4:0] OP_JUMP  = 5'h0B;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_RD  = 4'd2,
    S_ALU_WB  = 4'd3,
    S_LOAD_WB = 4'd4,
    S_MEM_WR  = 4'd5,
    S_IMM_EX  = 4'd6,
    S_BRANCH  = 4'd7,
    S_HALT    = 4'd8
  } state_e;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  localparam logic [1:0] SRCB_MEM = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_IR  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       acc_write;
    logic       acc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= OP_JUMP) || (op == OP_HALT);
  endfunction

  function automatic logic [2:0] alu_op_for(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Successor of DECODE; NOP and undefined opcodes both fall back to FETCH.
  function automatic state_e decode_next(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: return S_MEM_RD;
      OP_STORE:                               return S_MEM_WR;
      OP_ADDI, OP_LDI:                        return S_IMM_EX;
      OP_BEQZ, OP_BNEZ, OP_JUMP:              return S_BRANCH;
      OP_HALT:                                return S_HALT;
      default:                                return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational control-word decoder: current state plus opcode (and the Mealy
// inputs MemReady/AccZero) to every datapath enable and select.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [4:0] opcode,
  input  logic       mem_ready,
  input  logic       acc_zero,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_ONE;
        cw.alu_op    = ALU_ADD;
        cw.pc_source = PCSRC_ALU;
        // IR load and PC+1 commit only in the cycle memory delivers the word.
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        cw.illegal = ~is_legal(opcode);
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_ALU_WB: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_MEM;
        cw.alu_op    = alu_op_for(opcode);
        cw.acc_write = 1'b1;
      end
      S_LOAD_WB: begin
        cw.acc_write = 1'b1;
        cw.acc_src   = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_IMM_EX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = (opcode == OP_LDI) ? ALU_PASS_B : ALU_ADD;
        cw.acc_write = 1'b1;
      end
      S_BRANCH: begin
        cw.pc_source = PCSRC_IR;
        case (opcode)
          OP_JUMP: cw.pc_write      = 1'b1;
          OP_BEQZ: cw.pc_write_cond = acc_zero;
          OP_BNEZ: cw.pc_write_cond = ~acc_zero;
          default: ;
        endcase
      end
      S_HALT: begin
        cw.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator processor: sequences
// fetch/decode/execute with a ready handshake on every memory access.
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Opcode,
  input  logic       AccZero,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ACCWrite,
  output logic       ACCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Halted,
  output logic       Illegal
);

  state_e     state_q, state_d;
  logic       in_rst_q, in_rst_d;
  ctrl_word_t cw_raw, cw;

  assign in_rst_d = ~reset;

  always_ff @(posedge clk) begin
    in_rst_q <= in_rst_d;
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // The cycle after a sampled reset is held in FETCH with outputs gated, so a
  // MemReady arriving then cannot start a fetch without its IRWrite.
  always_comb begin
    state_d = state_q;
    if (in_rst_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:   if (MemReady) state_d = S_DECODE;
        S_DECODE:  state_d = decode_next(Opcode);
        S_MEM_RD:  if (MemReady) state_d = (Opcode == OP_LOAD) ? S_LOAD_WB : S_ALU_WB;
        S_MEM_WR:  if (MemReady) state_d = S_FETCH;
        S_ALU_WB,
        S_LOAD_WB,
        S_IMM_EX,
        S_BRANCH:  state_d = S_FETCH;
        S_HALT:    state_d = S_HALT;
        default:   state_d = S_FETCH;
      endcase
    end
  end

  ctrl_outdec u_outdec (
    .state     (state_q),
    .opcode    (Opcode),
    .mem_ready (MemReady),
    .acc_zero  (AccZero),
    .cw        (cw_raw)
  );

  assign cw = in_rst_q ? '0 : cw_raw;

  assign IRWrite     = cw.ir_write;
  assign PCWrite     = cw.pc_write;
  assign PCWriteCond = cw.pc_write_cond;
  assign IorD        = cw.iord;
  assign MemRead     = cw.mem_read;
  assign MemWrite    = cw.mem_write;
  assign ACCWrite    = cw.acc_write;
  assign ACCSrc      = cw.acc_src;
  assign ALUSrcA     = cw.alu_src_a;
  assign ALUSrcB     = cw.alu_src_b;
  assign ALUOp       = cw.alu_op;
  assign PCSource    = cw.pc_source;
  assign Halted      = cw.halted;
  assign Illegal     = cw.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level step model (one queue of micro-steps
// per fetched opcode) is compared every cycle, plus directed literal expectations.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       MemReady = 1'b0;
  logic       AccZero = 1'b0;
  logic [4:0] Opcode = 5'h00;

  logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       ACCWrite, ACCSrc, ALUSrcA, Halted, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [17:0] dut_vec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .AccZero(AccZero), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .ACCWrite(ACCWrite), .ACCSrc(ACCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Halted(Halted), .Illegal(Illegal)
  );

  assign dut_vec = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, ACCWrite,
                    ACCSrc, ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted, Illegal};

  // Micro-steps an instruction goes through, as described by the opcode table.
  localparam int K_FETCH = 0, K_DECODE = 1, K_RD = 2, K_ALU = 3, K_LD = 4;
  localparam int K_WR = 5, K_IMM = 6, K_BR = 7, K_HALT = 8;

  int         m_steps[$];
  logic       m_rst = 1'b1;
  logic [4:0] m_op = 5'h00;
  logic [4:0] nxt_op = 5'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic build(input logic [4:0] op);
    m_steps.push_back(K_DECODE);
    case (op)
      5'h01, 5'h02, 5'h03, 5'h04: begin m_steps.push_back(K_RD); m_steps.push_back(K_ALU); end
      5'h07:                      begin m_steps.push_back(K_RD); m_steps.push_back(K_LD); end
      5'h08:                      m_steps.push_back(K_WR);
      5'h05, 5'h06:               m_steps.push_back(K_IMM);
      5'h09, 5'h0A, 5'h0B:        m_steps.push_back(K_BR);
      5'h1F:                      m_steps.push_back(K_HALT);
      default: ;
    endcase
  endtask

  // Advance the model by one clock edge using the inputs held during the past cycle.
  task automatic model_edge();
    int k;
    if (!reset) begin
      m_rst = 1'b1;
      m_steps.delete();
      m_steps.push_back(K_FETCH);
    end else if (m_rst) begin
      m_rst = 1'b0;
    end else if (m_steps.size() > 0) begin
      k = m_steps[0];
      if (!((k == K_FETCH || k == K_RD || k == K_WR) && !MemReady) && k != K_HALT) begin
        void'(m_steps.pop_front());
        if (k == K_FETCH) begin
          m_op = nxt_op;
          build(m_op);
        end
        if (m_steps.size() == 0) m_steps.push_back(K_FETCH);
      end
    end
  endtask

  function automatic logic [17:0] model_out();
    logic ir, pw, pwc, iord, mr, mw, aw, as, asa, h, il;
    logic [1:0] sb, ps;
    logic [2:0] op;
    {ir, pw, pwc, iord, mr, mw, aw, as, asa, h, il} = '0;
    sb = 2'b00; ps = 2'b00; op = 3'b000;
    if (!m_rst && m_steps.size() > 0) begin
      case (m_steps[0])
        K_FETCH:  begin mr = 1'b1; sb = 2'b01; ir = MemReady; pw = MemReady; end
        K_DECODE: il = !(m_op <= 5'h0B || m_op == 5'h1F);
        K_RD:     begin mr = 1'b1; iord = 1'b1; end
        K_ALU:    begin asa = 1'b1; aw = 1'b1; op = 3'(m_op - 5'd1); end
        K_LD:     begin aw = 1'b1; as = 1'b1; end
        K_WR:     begin mw = 1'b1; iord = 1'b1; end
        K_IMM:    begin asa = 1'b1; sb = 2'b10; aw = 1'b1; op = (m_op == 5'h05) ? 3'b000 : 3'b100; end
        K_BR: begin
          ps  = 2'b10;
          pw  = (m_op == 5'h0B);
          pwc = (m_op == 5'h09) ? AccZero : ((m_op == 5'h0A) ? !AccZero : 1'b0);
        end
        K_HALT:   h = 1'b1;
        default: ;
      endcase
    end
    return {ir, pw, pwc, iord, mr, mw, aw, as, asa, sb, op, ps, h, il};
  endfunction

  always @(negedge clk) begin : compare_proc
    logic [17:0] e;
    e = model_out();
    check("ctrl_word", 32'(dut_vec), 32'(e));
    check("mem_rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
  end

  task automatic cyc(input logic rst_n, input logic mr, input logic az);
    @(posedge clk);
    model_edge();
    #1;
    Opcode = m_op;
    reset = rst_n; MemReady = mr; AccZero = az;
    @(negedge clk);
  endtask

  function automatic logic [4:0] rand_op();
    int r;
    r = int'($urandom_range(0, 19));
    if (r <= 11) return 5'(r);
    if (r <= 13) return 5'($urandom_range(12, 30));
    if (r == 14) return 5'h1F;
    return 5'($urandom_range(0, 11));
  endfunction

  initial begin
    int halt_cycles;
    logic do_rst;

    nxt_op = 5'h01;
    repeat (3) begin
      cyc(1'b0, 1'b1, 1'b0);
      check("reset_outputs_zero", 32'(dut_vec), 32'd0);
    end
    cyc(1'b1, 1'b1, 1'b0);
    check("release_cycle_zero", 32'(dut_vec), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check("first_fetch_irwrite", 32'(IRWrite), 32'd1);
    check("first_fetch_pcwrite", 32'(PCWrite), 32'd1);

    // ADD with two wait cycles on the operand read
    cyc(1'b1, 1'b0, 1'b0);
    check("add_decode_zero", 32'(dut_vec), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, (i == 2), 1'b0);
      check("add_memrd", 32'({MemRead, IorD}), 32'd3);
    end
    cyc(1'b1, 1'b0, 1'b0);
    check("add_aluop", 32'(ALUOp), 32'd0);
    check("add_accwrite", 32'(ACCWrite), 32'd1);

    // BEQZ taken then not taken
    nxt_op = 5'h09;
    cyc(1'b1, 1'b1, 1'b1);
    check("beqz_fetch", 32'({MemRead, IorD, IRWrite}), 32'd5);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check("beqz_taken_cond", 32'(PCWriteCond), 32'd1);
    check("beqz_taken_pcsrc", 32'(PCSource), 32'd2);
    cyc(1'b1, 1'b1, 1'b0);
    check("beqz2_fetch", 32'(IRWrite), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("beqz_not_taken_cond", 32'(PCWriteCond), 32'd0);

    // STORE with one wait cycle
    nxt_op = 5'h08;
    cyc(1'b1, 1'b1, 1'b0);
    check("store_fetch", 32'(MemRead), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("store_wait", 32'({MemWrite, MemRead, ACCWrite}), 32'd4);
    cyc(1'b1, 1'b1, 1'b0);
    check("store_ready", 32'(MemWrite), 32'd1);

    // Illegal opcode 0C
    nxt_op = 5'h0C;
    cyc(1'b1, 1'b1, 1'b0);
    check("store_back_to_fetch", 32'({MemRead, MemWrite, IRWrite}), 32'd5);
    cyc(1'b1, 1'b0, 1'b0);
    check("illegal_pulse", 32'(Illegal), 32'd1);
    nxt_op = 5'h1F;
    cyc(1'b1, 1'b0, 1'b0);
    check("illegal_one_cycle", 32'({Illegal, MemRead}), 32'd1);

    // HALT sticks until reset
    cyc(1'b1, 1'b1, 1'b0);
    check("halt_fetch", 32'(IRWrite), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("halted_hold", 32'(Halted), 32'd1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("halt_reset_zero", 32'(dut_vec), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check("refetch_after_halt", 32'(IRWrite), 32'd1);

    // Randomized traffic with wait states and occasional mid-instruction resets
    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      nxt_op = rand_op();
      if (m_steps.size() > 0 && m_steps[0] == K_HALT) halt_cycles++;
      else halt_cycles = 0;
      do_rst = ($urandom_range(0, 79) == 0) || (halt_cycles > 12);
      cyc(!do_rst, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
